// File: rtl/msf_pkg.sv
// Shared MSF definitions: symbol layout, transmitter states and slot positions
// used by the encoder, the bit sampler and the frame blocks.
package msf_pkg;

  localparam int SLOTS_PER_SEC    = 10;
  localparam int MARKER_OFF_SLOTS = 5;
  localparam int SLOT_A           = 1;
  localparam int SLOT_B           = 2;

  typedef struct packed {
    logic marker;
    logic a;
    logic b;
  } msf_sym_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/msf_slot_timer.sv
// Tick and 100 ms slot counters for one MSF second; the end-of-slot and
// end-of-second flags mark the last tick of the respective period.
module msf_slot_timer #(
  parameter int TICKS_PER_SLOT = 1000,
  parameter int SLOTS_PER_SEC  = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       enable_i,
  output logic [3:0] slot_o,
  output logic       slot_end_o,
  output logic       sec_end_o
);

  localparam int              TW        = $clog2(TICKS_PER_SLOT);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS_PER_SLOT - 1);
  localparam logic [3:0]      SLOT_LAST = 4'(SLOTS_PER_SEC - 1);

  logic [TW-1:0] tick;

  assign slot_end_o = enable_i && (tick == TICK_LAST);
  assign sec_end_o  = slot_end_o && (slot_o == SLOT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick   <= '0;
      slot_o <= '0;
    end else if (clear_i) begin
      tick   <= '0;
      slot_o <= '0;
    end else if (enable_i) begin
      if (slot_end_o) begin
        tick   <= '0;
        slot_o <= sec_end_o ? 4'd0 : slot_o + 4'd1;
      end else begin
        tick <= tick + TW'(1);
      end
    end
  end

endmodule

// File: rtl/msf_symbol_encoder.sv
// MSF transmitter: turns per-second symbols into the carrier on/off waveform,
// with a one-entry holding register so seconds can run back-to-back.
module msf_symbol_encoder #(
  parameter int TICKS_PER_SLOT = 1000,
  parameter int SLOTS_PER_SEC  = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sym_valid_i,
  output logic sym_ready_o,
  input  logic sym_marker_i,
  input  logic sym_a_i,
  input  logic sym_b_i,
  output logic data_o,
  output logic sec_o,
  output logic busy_o,
  output logic underrun_o
);

  import msf_pkg::*;

  tx_state_t  state;
  msf_sym_t   in_sym, hold, cur, cur_nx;
  logic       hold_valid, hold_valid_nx, ready, accept, load;
  logic       data, sec, underrun;
  logic [3:0] slot, slot_nx;
  logic       slot_end, sec_end;

  function automatic logic is_off(input msf_sym_t s, input logic [3:0] slot_idx);
    if (s.marker) return slot_idx < 4'(MARKER_OFF_SLOTS);
    return (slot_idx == 4'd0) ||
           (s.a && (slot_idx == 4'(SLOT_A))) ||
           (s.b && (slot_idx == 4'(SLOT_B)));
  endfunction

  msf_slot_timer #(
    .TICKS_PER_SLOT(TICKS_PER_SLOT),
    .SLOTS_PER_SEC (SLOTS_PER_SEC)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (state == IDLE),
    .enable_i  (state == SEND),
    .slot_o    (slot),
    .slot_end_o(slot_end),
    .sec_end_o (sec_end)
  );

  assign in_sym        = msf_sym_t'{marker: sym_marker_i, a: sym_a_i, b: sym_b_i};
  assign accept        = sym_valid_i && ready;
  assign load          = hold_valid && ((state == IDLE) || sec_end);
  assign hold_valid_nx = accept || (hold_valid && !load);
  assign cur_nx        = load ? hold : cur;
  // Outputs are computed from the slot the counters move to on this edge.
  assign slot_nx       = sec_end ? 4'd0 : (slot_end ? slot + 4'd1 : slot);

  // Symbol payload registers carry no reset; hold_valid qualifies them.
  always_ff @(posedge clk_i) begin
    if (accept) hold <= in_sym;
    if (load)   cur  <= hold;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      ready      <= 1'b1;
      data       <= 1'b1;
      sec        <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      hold_valid <= hold_valid_nx;
      ready      <= !hold_valid_nx;
      sec        <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_valid) begin
            state <= SEND;
            sec   <= 1'b1;
            data  <= !is_off(hold, 4'd0);
          end else begin
            data  <= 1'b1;
          end
        end
        SEND: begin
          if (sec_end && !hold_valid) begin
            state    <= IDLE;
            underrun <= 1'b1;
            data     <= 1'b1;
          end else begin
            sec  <= sec_end;
            data <= !is_off(cur_nx, slot_nx);
          end
        end
        default: begin
          state <= IDLE;
          data  <= 1'b1;
        end
      endcase
    end
  end

  assign sym_ready_o = ready;
  assign data_o      = data;
  assign sec_o       = sec;
  assign underrun_o  = underrun;
  assign busy_o      = (state == SEND);

endmodule

// File: tb/tb_msf_symbol_encoder.sv
// Bench for msf_symbol_encoder: vector table, directed corner sequences and a
// random loopback decode, all cross-checked against a per-cycle reference model.
`timescale 1ns/1ps
module tb_msf_symbol_encoder;

  localparam int TPS = 4;
  localparam int SPS = 10;
  localparam int CPS = TPS * SPS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sym_valid = 1'b0, sym_marker = 1'b0, sym_a = 1'b0, sym_b = 1'b0;
  logic sym_ready, data, sec, busy, underrun;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  msf_symbol_encoder #(.TICKS_PER_SLOT(TPS), .SLOTS_PER_SEC(SPS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sym_valid_i (sym_valid),
    .sym_ready_o (sym_ready),
    .sym_marker_i(sym_marker),
    .sym_a_i     (sym_a),
    .sym_b_i     (sym_b),
    .data_o      (data),
    .sec_o       (sec),
    .busy_o      (busy),
    .underrun_o  (underrun)
  );

  always #5 clk = ~clk;

  function automatic bit sym_off(input bit m, input bit a, input bit b, input int s);
    if (m) return s < 5;
    return (s == 0) || (s == 1 && a) || (s == 2 && b);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a second is a position 0..CPS-1 plus the symbol being sent.
  bit m_hv = 0, m_active = 0, acc;
  bit m_hm, m_ha, m_hb, m_cm, m_ca, m_cb;
  int m_pos = 0;
  logic e_data = 1, e_sec = 0, e_und = 0, e_ready = 1, e_busy = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_hv = 0; m_active = 0; m_pos = 0;
      e_data = 1; e_sec = 0; e_und = 0; e_ready = 1; e_busy = 0;
    end else begin
      acc = sym_valid && !m_hv;
      e_sec = 0; e_und = 0;
      if (!m_active) begin
        if (m_hv) begin
          {m_cm, m_ca, m_cb} = {m_hm, m_ha, m_hb};
          m_hv = 0; m_active = 1; m_pos = 0; e_sec = 1;
        end
      end else if (m_pos == CPS - 1) begin
        if (m_hv) begin
          {m_cm, m_ca, m_cb} = {m_hm, m_ha, m_hb};
          m_hv = 0; m_pos = 0; e_sec = 1;
        end else begin
          m_active = 0; m_pos = 0; e_und = 1;
        end
      end else begin
        m_pos++;
      end
      if (acc) begin
        {m_hm, m_ha, m_hb} = {sym_marker, sym_a, sym_b};
        m_hv = 1;
      end
      e_data  = m_active ? !sym_off(m_cm, m_ca, m_cb, m_pos / TPS) : 1'b1;
      e_ready = !m_hv;
      e_busy  = m_active;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en)
      check("cycle", {data, sec, underrun, sym_ready, busy},
            {e_data, e_sec, e_und, e_ready, e_busy});
  end

  task automatic push(input bit m, input bit a, input bit b, input bit jit, output bit to);
    int n;
    n = 0; to = 0;
    @(negedge clk);
    while (!sym_ready && n < 400) begin
      sym_valid = 1;
      if (jit) {sym_marker, sym_a, sym_b} = 3'($urandom);
      else     {sym_marker, sym_a, sym_b} = {m, a, b};
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      to = 1; sym_valid = 0;
      return;
    end
    sym_valid = 1;
    {sym_marker, sym_a, sym_b} = {m, a, b};
    @(negedge clk);
    sym_valid = 0;
  endtask

  task automatic wait_sec(input string name);
    int n;
    n = 0;
    while (sec !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, sec, 1);
  endtask

  task automatic wait_underrun(input string name);
    int n;
    n = 0;
    while (underrun !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, underrun, 1);
    @(negedge clk);
  endtask

  typedef struct {
    bit          m, a, b;
    logic [39:0] off;
  } vec_t;
  vec_t tbl[6];

  bit rm[20], ra[20], rb[20];
  bit to;
  int bad;

  initial begin
    tbl[0] = '{0, 0, 0, 40'h00_0000_000F};
    tbl[1] = '{0, 1, 0, 40'h00_0000_00FF};
    tbl[2] = '{0, 0, 1, 40'h00_0000_0F0F};
    tbl[3] = '{0, 1, 1, 40'h00_0000_0FFF};
    tbl[4] = '{1, 1, 1, 40'h00_000F_FFFF};
    tbl[5] = '{1, 0, 0, 40'h00_000F_FFFF};
    for (int k = 0; k < 20; k++) begin
      rm[k] = ($urandom_range(0, 3) == 0);
      ra[k] = 1'($urandom);
      rb[k] = 1'($urandom);
    end

    repeat (3) @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    check("reset", {data, sec, underrun, sym_ready, busy}, 5'b10010);

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!(data && !sec && !underrun && sym_ready && !busy)) bad++;
    end
    check("idle100", bad, 0);

    // Table: back-to-back seconds, each compared against its off-slot mask.
    fork
      begin
        bit pto;
        for (int i = 0; i < 6; i++) begin
          push(tbl[i].m, tbl[i].a, tbl[i].b, 0, pto);
          check("push_tbl", pto, 0);
        end
      end
      begin
        logic [39:0] mask;
        for (int i = 0; i < 6; i++) begin
          if (i == 0) wait_sec("tbl_start");
          else        check($sformatf("tbl_contig_%0d", i), sec, 1);
          mask = '0;
          for (int c = 0; c < CPS; c++) begin
            mask[c] = !data;
            @(negedge clk);
          end
          check($sformatf("tbl_mask_%0d", i), mask, tbl[i].off);
        end
        check("tbl_underrun", {underrun, busy}, 2'b10);
      end
    join
    @(negedge clk);

    // Symbol arrives on the final cycle of a second with the hold empty.
    push(0, 0, 0, 0, to);
    check("push_bnd", to, 0);
    wait_sec("bnd_start");
    repeat (CPS - 1) @(negedge clk);
    sym_valid = 1; {sym_marker, sym_a, sym_b} = 3'b010;
    @(negedge clk);
    sym_valid = 0;
    check("bnd_underrun", {underrun, sec, busy}, 3'b100);
    @(negedge clk);
    check("bnd_restart", {sec, busy}, 2'b11);
    wait_underrun("bnd_end");

    // Valid held against a full hold register with changing data.
    push(0, 0, 1, 0, to);
    check("push_h1", to, 0);
    wait_sec("hold_sec1");
    push(0, 1, 1, 0, to);
    check("push_h2", to, 0);
    @(negedge clk);
    sym_valid = 1; {sym_marker, sym_a, sym_b} = 3'($urandom);
    check("ready_full", sym_ready, 0);
    bad = 0;
    while (sec !== 1'b1 && bad < 200) begin
      {sym_marker, sym_a, sym_b} = 3'($urandom);
      @(negedge clk);
      bad++;
    end
    check("load_seen", sec, 1);
    check("ready_after_load", sym_ready, 1);
    {sym_marker, sym_a, sym_b} = 3'b101;
    @(negedge clk);
    sym_valid = 0;
    check("accept_after_load", sym_ready, 0);
    wait_underrun("hold_end");

    // Asynchronous reset in the middle of an off slot.
    push(0, 1, 1, 0, to);
    check("push_rst", to, 0);
    wait_sec("rst_sec");
    repeat (10) @(negedge clk);
    check("pre_reset_data", data, 0);
    #2 rst_n = 0;
    #1 check("async_reset", {data, busy, sym_ready}, 3'b101);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);

    // Random loopback: decode each transmitted second from the waveform.
    fork
      begin
        bit pto;
        for (int k = 0; k < 20; k++) begin
          repeat ($urandom_range(0, 45)) @(negedge clk);
          push(rm[k], ra[k], rb[k], 1, pto);
          check("push_lb", pto, 0);
        end
      end
      begin
        bit off_s[SPS];
        logic [2:0] got, exp;
        for (int k = 0; k < 20; k++) begin
          wait_sec("lb_sec");
          for (int c = 0; c < CPS; c++) begin
            if (c % TPS == 1) off_s[c / TPS] = !data;
            @(negedge clk);
          end
          if (!off_s[0] || off_s[5] || off_s[6] || off_s[7] || off_s[8] || off_s[9])
            got = 3'b111;
          else if (off_s[1] && off_s[2] && off_s[3] && off_s[4])
            got = 3'b100;
          else if (off_s[3] || off_s[4])
            got = 3'b111;
          else
            got = {1'b0, off_s[1], off_s[2]};
          exp = rm[k] ? 3'b100 : {1'b0, ra[k], rb[k]};
          check($sformatf("lb_%0d", k), got, exp);
        end
      end
    join
    wait_underrun("lb_end");

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
